// File: rtl/free_list_pkg.sv
// free_list_pkg: shared processor sizing for rename (physical tags, RAT, free list)
package free_list_pkg;
  localparam int PREG_WIDTH = 6;
  localparam int NUM_PREG = 64;
  localparam int NUM_AREG = 32;
  localparam int AREG_WIDTH = $clog2(NUM_AREG);
  localparam int RAT_DEPTH = NUM_AREG;
  typedef logic [PREG_WIDTH-1:0] preg_t;
  typedef logic [AREG_WIDTH-1:0] areg_t;
endpackage

// File: rtl/free_list.sv
// free_list: circular free list of physical tags; FREE_LIST_FLUSH_EN adds commit tracking and flush recovery
module free_list
  import free_list_pkg::*;
#(
  parameter int PREG_WIDTH = free_list_pkg::PREG_WIDTH,
  parameter int NUM_PREG = free_list_pkg::NUM_PREG,
  parameter int NUM_AREG = free_list_pkg::NUM_AREG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  output logic [PREG_WIDTH-1:0] alloc_tag,
  output logic                  alloc_valid,
  input  logic                  free_en,
  input  logic [PREG_WIDTH-1:0] free_tag,
  output logic                  empty,
  output logic                  full,
  output logic [PREG_WIDTH:0]   free_count
`ifdef FREE_LIST_FLUSH_EN
  ,
  input  logic                  commit_en,
  input  logic                  flush
`endif
);
  localparam int PW = $clog2(NUM_PREG);
  localparam int CW = PREG_WIDTH + 1;
  logic [PREG_WIDTH-1:0] entry [NUM_PREG];
  logic [PW-1:0] head, tail, head_nx, tail_nx;
  logic [CW-1:0] count, count_nx;
  logic alloc_ok, free_ok;
`ifdef FREE_LIST_FLUSH_EN
  logic [PW-1:0] commit_head, commit_head_nx;
  function automatic logic [CW-1:0] ring_dist(input logic [PW-1:0] t, input logic [PW-1:0] h);
    return t >= h ? CW'(t) - CW'(h) : CW'(t) + CW'(NUM_PREG) - CW'(h);
  endfunction
`endif
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(NUM_PREG - 1) ? '0 : p + PW'(1);
  endfunction
  // outputs from registered state, then accepted operations and next pointers/count
  always_comb begin
    alloc_tag = entry[head];
    empty = count == '0;
    full = count == CW'(NUM_PREG - 1);
    alloc_valid = !empty;
    free_count = count;
    free_ok = free_en && free_tag != '0 && !full;
    tail_nx = free_ok ? inc(tail) : tail;
`ifdef FREE_LIST_FLUSH_EN
    alloc_ok = alloc_req && !empty && !flush;
    commit_head_nx = commit_en ? inc(commit_head) : commit_head;
    head_nx = flush ? commit_head_nx : alloc_ok ? inc(head) : head;
    count_nx = flush ? ring_dist(tail_nx, head_nx) : count + CW'(free_ok) - CW'(alloc_ok);
`else
    alloc_ok = alloc_req && !empty;
    head_nx = alloc_ok ? inc(head) : head;
    count_nx = count + CW'(free_ok) - CW'(alloc_ok);
`endif
  end
  // reset loads the non-architectural tags; otherwise write returned tag and advance pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREG; i++)
        entry[i] <= i < NUM_PREG - NUM_AREG ? PREG_WIDTH'(NUM_AREG + i) : '0;
      head <= '0;
      tail <= PW'(NUM_PREG - NUM_AREG);
      count <= CW'(NUM_PREG - NUM_AREG);
`ifdef FREE_LIST_FLUSH_EN
      commit_head <= '0;
`endif
    end else begin
      if (free_ok) entry[tail] <= free_tag;
      head <= head_nx;
      tail <= tail_nx;
      count <= count_nx;
`ifdef FREE_LIST_FLUSH_EN
      commit_head <= commit_head_nx;
`endif
    end
  end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: randomized and directed checks of free_list against a queue model
module tb_free_list;
  logic clk = 0, rst = 0, alloc_req = 0, free_en = 0;
  logic [5:0] free_tag = 0, alloc_tag;
  logic alloc_valid, empty, full;
  logic [6:0] free_count;
`ifdef FREE_LIST_FLUSH_EN
  logic commit_en = 0, flush = 0;
`endif
  int q[$];
  int inflight[$];
  int checks = 0, errors = 0;

  free_list dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_tag(alloc_tag), .alloc_valid(alloc_valid),
    .free_en(free_en), .free_tag(free_tag), .empty(empty), .full(full), .free_count(free_count)
`ifdef FREE_LIST_FLUSH_EN
    , .commit_en(commit_en), .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    inflight.delete();
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
  endtask

  task automatic step(input logic a, input logic f, input logic [5:0] t);
    bit acc_a, acc_f;
    int tag;
    alloc_req = a; free_en = f; free_tag = t;
    @(posedge clk);
    acc_a = a && q.size() > 0;
    acc_f = f && t != 0 && q.size() < 63;
    if (acc_a) begin tag = q.pop_front(); inflight.push_back(tag); end
    if (acc_f) q.push_back(int'(t));
    #1; alloc_req = 0; free_en = 0; free_tag = 0;
  endtask

  task automatic test_reset();
    alloc_req = 1; free_en = 1; free_tag = 5; rst = 1;
    @(posedge clk); #1;
    rst = 0; alloc_req = 0; free_en = 0; free_tag = 0;
    model_reset();
    checks++; if (alloc_tag !== 6'd32) begin errors++; $display("FAIL reset_tag got %0d exp 32", alloc_tag); end
    checks++; if (free_count !== 7'd32) begin errors++; $display("FAIL reset_count got %0d exp 32", free_count); end
    checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %0b exp 1", alloc_valid); end
    checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%0b full=%0b exp 0 0", empty, full); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 32; i++) begin
      checks++; if (alloc_tag !== 6'(32 + i)) begin errors++; $display("FAIL drain_tag[%0d] got %0d exp %0d", i, alloc_tag, 32 + i); end
      step(1, 0, 0);
    end
    checks++; if (empty !== 1'b1 || alloc_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got empty=%0b valid=%0b exp 1 0", empty, alloc_valid); end
    checks++; if (free_count !== 7'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", free_count); end
    step(1, 0, 0);
    checks++; if (free_count !== 7'd0 || empty !== 1'b1) begin errors++; $display("FAIL drain_extra got count=%0d empty=%0b exp 0 1", free_count, empty); end
  endtask

  task automatic test_refill();
    alloc_req = 1; free_en = 1; free_tag = 40; #1;
    checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL refill_bypass got valid=%0b exp 0", alloc_valid); end
    step(1, 1, 40);
    checks++; if (alloc_tag !== 6'd40 || alloc_valid !== 1'b1) begin errors++; $display("FAIL refill_first got tag=%0d valid=%0b exp 40 1", alloc_tag, alloc_valid); end
    checks++; if (free_count !== 7'd1) begin errors++; $display("FAIL refill_count1 got %0d exp 1", free_count); end
    step(0, 1, 35);
    checks++; if (free_count !== 7'd2 || alloc_tag !== 6'd40) begin errors++; $display("FAIL refill_count2 got count=%0d tag=%0d exp 2 40", free_count, alloc_tag); end
    step(1, 0, 0);
    checks++; if (alloc_tag !== 6'd35 || free_count !== 7'd1) begin errors++; $display("FAIL refill_second got tag=%0d count=%0d exp 35 1", alloc_tag, free_count); end
  endtask

  task automatic test_simultaneous();
    for (int t = 10; t < 14; t++) step(0, 1, 6'(t));
    checks++; if (free_count !== 7'd5) begin errors++; $display("FAIL simul_pre got %0d exp 5", free_count); end
    step(1, 1, 7);
    checks++; if (free_count !== 7'd5 || alloc_tag !== 6'd10) begin errors++; $display("FAIL simul_count got count=%0d tag=%0d exp 5 10", free_count, alloc_tag); end
    for (int k = 0; k < 4; k++) step(1, 0, 0);
    checks++; if (alloc_tag !== 6'd7 || free_count !== 7'd1) begin errors++; $display("FAIL simul_tail got tag=%0d count=%0d exp 7 1", alloc_tag, free_count); end
    step(0, 1, 0);
    checks++; if (free_count !== 7'd1 || alloc_tag !== 6'd7) begin errors++; $display("FAIL zero_drop got count=%0d tag=%0d exp 1 7", free_count, alloc_tag); end
  endtask

  task automatic test_wrap_full();
    rst = 1; @(posedge clk); #1; rst = 0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, 6'($urandom_range(0, 63)));
      checks++; if (free_count !== 7'(q.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d exp %0d", n, free_count, q.size()); end
      checks++; if (empty !== (q.size() == 0) || full !== (q.size() == 63)) begin errors++; $display("FAIL rand_flags[%0d] got empty=%0b full=%0b size=%0d", n, empty, full, q.size()); end
      if (q.size() > 0) begin
        checks++; if (alloc_tag !== 6'(q[0])) begin errors++; $display("FAIL rand_tag[%0d] got %0d exp %0d", n, alloc_tag, q[0]); end
      end
    end
    for (int n = 0; n < 100 && q.size() < 63; n++) step(0, 1, 6'($urandom_range(1, 63)));
    checks++; if (full !== 1'b1 || free_count !== 7'd63) begin errors++; $display("FAIL full_set got full=%0b count=%0d exp 1 63", full, free_count); end
    step(0, 1, 9);
    checks++; if (full !== 1'b1 || free_count !== 7'd63) begin errors++; $display("FAIL full_drop got full=%0b count=%0d exp 1 63", full, free_count); end
    for (int n = 0; n < 63; n++) begin
      checks++; if (alloc_tag !== 6'(q[0])) begin errors++; $display("FAIL wrap_drain[%0d] got %0d exp %0d", n, alloc_tag, q[0]); end
      step(1, 0, 0);
    end
    checks++; if (empty !== 1'b1 || free_count !== 7'd0) begin errors++; $display("FAIL wrap_empty got empty=%0b count=%0d exp 1 0", empty, free_count); end
  endtask

`ifdef FREE_LIST_FLUSH_EN
  task automatic test_flush();
    int tag;
    rst = 1; @(posedge clk); #1; rst = 0;
    model_reset();
    for (int k = 0; k < 4; k++) step(1, 0, 0);
    commit_en = 1; @(posedge clk);
    tag = inflight.pop_front();
    #1; commit_en = 0;
    flush = 1; alloc_req = 1; @(posedge clk);
    while (inflight.size() > 0) q.push_front(inflight.pop_back());
    #1; flush = 0; alloc_req = 0;
    checks++; if (free_count !== 7'd31 || free_count !== 7'(q.size())) begin errors++; $display("FAIL flush_count got %0d exp 31", free_count); end
    checks++; if (alloc_tag !== 6'd33 || alloc_tag !== 6'(q[0])) begin errors++; $display("FAIL flush_tag got %0d exp 33 (committed %0d)", alloc_tag, tag); end
  endtask
`endif

  initial begin
    test_reset();
    test_drain();
    test_refill();
    test_simultaneous();
    test_wrap_full();
`ifdef FREE_LIST_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter PREG_WIDTH, default 6, meaning physical tag width.
REQ-002 SHALL have parameter NUM_PREG, default 64, meaning physical register count and list depth.
REQ-003 SHALL have parameter NUM_AREG, default 32, meaning architectural registers identity-mapped at reset.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port alloc_req  in  1  rename consumes one free tag this cycle.
REQ-007 SHALL have port alloc_tag  out  PREG_WIDTH  tag at head, show-ahead.
REQ-008 SHALL have port alloc_valid  out  1  alloc_tag is valid (list not empty).
REQ-009 SHALL have port free_en  in  1  commit returns an old destination tag.
REQ-010 SHALL have port free_tag  in  PREG_WIDTH  tag being returned.
REQ-011 SHALL have port empty  out  1  no free tags.
REQ-012 SHALL have port full  out  1  count equals NUM_PREG-1.
REQ-013 SHALL have port free_count  out  PREG_WIDTH+1  number of free tags held.

Function
REQ-014 SHALL store tags in a circular buffer of NUM_PREG entries with head/tail pointers wrapping modulo NUM_PREG.
REQ-015 SHALL drive alloc_tag combinationally from entry[head]; alloc_valid = !empty.
REQ-016 SHALL, on alloc_req with alloc_valid, advance head by 1 at the next edge; alloc_req when empty SHALL be ignored, with no state change.
REQ-017 SHALL, on free_en with free_tag != 0 and !full, write entry[tail] <= free_tag and advance tail by 1; free_tag == 0 SHALL be dropped (x0 tag never freed).
REQ-018 SHALL drop free_en when full, leaving all state unchanged.
REQ-019 SHALL, on simultaneous accepted alloc and free, update both pointers and leave free_count unchanged; otherwise free_count changes +1 per accepted free and -1 per accepted alloc.
REQ-020 SHALL NOT bypass free_tag to alloc_tag in the same cycle; an empty list stays unable to allocate until the cycle after the free.
REQ-021 SHALL derive empty = (free_count == 0) and full = (free_count == NUM_PREG-1) from registered free_count.

Reset
REQ-022 SHALL, on rst high at a clock edge, load entry[i] = NUM_AREG+i for i in 0..NUM_PREG-NUM_AREG-1, set head = 0, tail = NUM_PREG-NUM_AREG, and set free_count = NUM_PREG-NUM_AREG.
REQ-023 SHALL give rst priority over alloc, free and flush, including mid-operation; out of reset alloc_tag = NUM_AREG, alloc_valid = 1, empty = 0, full = 0.

Configuration
REQ-024 SHALL, when macro FREE_LIST_FLUSH_EN is defined, add ports commit_en in 1 (a tag-allocating instruction retired) and flush in 1 (mispredict recovery).
REQ-025 SHALL, with FREE_LIST_FLUSH_EN, keep a commit_head pointer (reset 0) advancing by 1 on each commit_en.
REQ-026 SHALL, with FREE_LIST_FLUSH_EN and flush high, set head <= commit_head (including a same-cycle commit_en), ignore alloc_req, still accept a same-cycle free, and set free_count to (tail_next - head_next) mod NUM_PREG.
REQ-027 SHALL, without FREE_LIST_FLUSH_EN, omit commit_en, flush and commit_head entirely, with behaviour otherwise identical.

Structure
REQ-028 SHALL take PREG_WIDTH, NUM_PREG and NUM_AREG defaults from the shared processor package, alongside the register-alias-table constants.
REQ-029 SHALL be a single module with no sub-modules; the pointer/count logic is one sequential block plus one combinational output block.

Verification
REQ-030 SHALL check reset: rst 1 cycle -> alloc_tag=32, free_count=32, alloc_valid=1.
REQ-031 SHALL check drain: 32 consecutive alloc_req -> tags 32..63 in order, then empty=1, and a 33rd alloc_req leaves the pointers unchanged.
REQ-032 SHALL check refill: after the drain, free_en with tags 40 then 35 -> alloc_tag=40 in the cycle after the first free, then 35, with free_count=2.
REQ-033 SHALL check simultaneous traffic: alloc_req and free_en(tag 7) in the same cycle at count 5 -> count stays 5, and 7 appears at the tail position; free_tag=0 -> dropped.
REQ-034 SHALL check wrap/full: push until free_count=63 -> full=1, a further free_en(9) is dropped, and pointers wrap past index 63 to 0 correctly.
REQ-035 SHALL check flush (FREE_LIST_FLUSH_EN): 4 allocs, 1 commit_en, then flush -> head=1, free_count=31, alloc_tag=33.
